// File: rtl/pll_nco.sv
// pll_nco: phase-accumulator clock synthesizer with a settling-time lock detector.
// Optional macro PLL_NCO_RELOCK_EN: any change of the tuning word forces re-acquisition.
module pll_nco #(
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] freq_word,
    output logic             outclk_0,
    output logic             outclk_stb,
    output logic             locked
);
    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [ACC_W-1:0] FW_MAX   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {ACQUIRE, LOCKED} state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] fw_clamp, fw_q, acc;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             outclk_d, retune;

    assign fw_clamp = (freq_word > FW_MAX) ? FW_MAX : freq_word;
    assign outclk_0 = acc[ACC_W-1];
    assign locked   = (state == LOCKED);

`ifdef PLL_NCO_RELOCK_EN
    logic [ACC_W-1:0] fw_d;
    // Preloaded during reset so release never looks like a retune.
    always_ff @(posedge refclk)
        fw_d <= rst_n ? fw_q : fw_clamp;
    assign retune = (fw_q != fw_d);
`else
    assign retune = 1'b0;
`endif

    always_ff @(posedge refclk) begin
        fw_q <= fw_clamp;
        if (!rst_n) begin
            acc        <= '0;
            outclk_d   <= 1'b0;
            outclk_stb <= 1'b0;
            state      <= ACQUIRE;
            cnt        <= '0;
        end else begin
            acc        <= acc + fw_q;
            outclk_d   <= outclk_0;
            outclk_stb <= outclk_0 & ~outclk_d;
            state      <= state_nx;
            cnt        <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (fw_q == '0 || retune) begin
            state_nx = ACQUIRE;
            cnt_nx   = '0;
        end else if (state == ACQUIRE) begin
            state_nx = (cnt == CNT_LAST) ? LOCKED : ACQUIRE;
            cnt_nx   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pll_nco.sv
// tb_pll_nco: randomized and directed checks of pll_nco against a phase/run-length model.
// Expectations for retunes follow PLL_NCO_RELOCK_EN when it is defined for the build.
module tb_pll_nco;
    localparam int L = 16;

    logic        refclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] freq_word = 32'h0;
    logic        outclk_0, outclk_stb, locked;

    int tests_run = 0;
    int fails     = 0;

`ifdef PLL_NCO_RELOCK_EN
    bit relock = 1'b1;
`else
    bit relock = 1'b0;
`endif

    // model: phase in plain modular arithmetic, lock as a run length of stable cycles
    logic [31:0] m_fw, m_fw_prev, m_phase;
    bit          m_o, m_oprev, m_stb, m_lock;
    int          m_run;

    pll_nco #(.ACC_W(32), .LOCK_CYCLES(L)) dut (
        .refclk(refclk), .rst_n(rst_n), .freq_word(freq_word),
        .outclk_0(outclk_0), .outclk_stb(outclk_stb), .locked(locked)
    );

    always #5 refclk = ~refclk;

    function automatic logic [31:0] clamp(input logic [31:0] w);
        return (w > 32'h8000_0000) ? 32'h8000_0000 : w;
    endfunction

    task automatic step();
        logic [31:0] fw_in;
        @(posedge refclk);
        fw_in = clamp(freq_word);
        if (!rst_n) begin
            m_phase = 0; m_oprev = 0; m_stb = 0; m_run = 0;
            m_fw = fw_in; m_fw_prev = fw_in;
        end else begin
            m_stb   = m_o && !m_oprev;
            m_oprev = m_o;
            m_phase = m_phase + m_fw;
            m_run   = (m_fw == 0 || (relock && m_fw != m_fw_prev)) ? 0 : m_run + 1;
            m_fw_prev = m_fw;
            m_fw      = fw_in;
        end
        m_o    = m_phase[31];
        m_lock = (m_run >= L);
        #1;
    endtask

    task automatic start(input logic [31:0] w);
        rst_n = 1'b0; freq_word = w;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start(32'h8000_0000);
        tests_run++;
        if ({outclk_0, outclk_stb, locked} !== 3'b000) begin
            fails++;
            $display("FAIL reset: got out/stb/lock=%b required 000", {outclk_0, outclk_stb, locked});
        end
    endtask

    task automatic test_half(input logic [31:0] w, input string nm);
        start(w);
        for (int e = 1; e <= 8; e++) begin
            step();
            tests_run++;
            if (outclk_0 !== e[0] || outclk_stb !== (e >= 2 && !e[0]) || locked !== 1'b0) begin
                fails++;
                $display("FAIL %s edge %0d: got out=%b stb=%b lock=%b required out=%b stb=%b lock=0",
                         nm, e, outclk_0, outclk_stb, locked, e[0], (e >= 2 && !e[0]));
            end
        end
    endtask

    task automatic test_quarter_lock();
        bit exp_o [7] = '{0, 1, 1, 0, 0, 1, 1};
        int strobes = 0;
        start(32'h4000_0000);
        for (int e = 1; e <= L + 1000; e++) begin
            step();
            if (e <= 7) begin
                tests_run++;
                if (outclk_0 !== exp_o[e-1]) begin
                    fails++;
                    $display("FAIL quarter_seq edge %0d: got %b required %b", e, outclk_0, exp_o[e-1]);
                end
            end
            if (e > 4 && e <= 20) strobes += outclk_stb;
            tests_run++;
            if (locked !== (e >= L)) begin
                fails++;
                $display("FAIL lock_time edge %0d: got %b required %b", e, locked, (e >= L));
            end
        end
        tests_run++;
        if (strobes != 4) begin
            fails++;
            $display("FAIL quarter_strobes: got %0d required 4", strobes);
        end
    endtask

    task automatic test_retune();
        int strobes = 0;
        freq_word = 32'h2000_0000;
        for (int s = 1; s <= 60; s++) begin
            step();
            if (s >= 20 && s < 52) strobes += outclk_stb;
            tests_run++;
            if (locked !== (relock ? (s == 1 || s >= 18) : 1'b1) || locked !== m_lock) begin
                fails++;
                $display("FAIL retune step %0d: got lock=%b required %b", s, locked,
                         relock ? (s == 1 || s >= 18) : 1'b1);
            end
        end
        tests_run++;
        if (strobes != 4) begin
            fails++;
            $display("FAIL retune_period: got %0d strobes in 32 cycles required 4", strobes);
        end
    endtask

    task automatic test_reset_midlock();
        rst_n = 1'b0;
        step();
        tests_run++;
        if ({outclk_0, outclk_stb, locked} !== 3'b000) begin
            fails++;
            $display("FAIL midlock_reset: got %b required 000", {outclk_0, outclk_stb, locked});
        end
        rst_n = 1'b1;
        for (int e = 1; e <= L + 4; e++) begin
            step();
            tests_run++;
            if (locked !== (e >= L) || outclk_0 !== m_o) begin
                fails++;
                $display("FAIL relock_after_reset edge %0d: got lock=%b out=%b required lock=%b out=%b",
                         e, locked, outclk_0, (e >= L), m_o);
            end
        end
    endtask

    task automatic test_zero();
        logic held;
        freq_word = 32'h0;
        step(); step();
        held = outclk_0;
        for (int s = 3; s <= 30; s++) begin
            step();
            tests_run++;
            if (outclk_0 !== held || outclk_stb !== 1'b0 || locked !== 1'b0) begin
                fails++;
                $display("FAIL zero_word step %0d: got out=%b stb=%b lock=%b required out=%b stb=0 lock=0",
                         s, outclk_0, outclk_stb, locked, held);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pick [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1000_0000, 32'h0300_0001};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0)
                freq_word = $urandom_range(0, 1) ? $urandom() : pick[$urandom_range(0, 4)];
            rst_n = ($urandom_range(0, 149) != 0);
            step();
            tests_run++;
            if (outclk_0 !== m_o || outclk_stb !== m_stb || locked !== m_lock) begin
                fails++;
                $display("FAIL random cycle %0d: got out=%b stb=%b lock=%b required out=%b stb=%b lock=%b",
                         c, outclk_0, outclk_stb, locked, m_o, m_stb, m_lock);
            end
        end
    endtask

    initial begin
        test_reset();
        test_half(32'h8000_0000, "half_rate");
        test_quarter_lock();
        test_retune();
        test_reset_midlock();
        test_zero();
        test_half(32'hFFFF_FFFF, "clamp");
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
